rf_write_arbiter: RTL
=====================

Name: rf_write_arbiter

Overview:
- Owns the single register-file write port.
- Shares it between two writers:
  - the in-order write-back stage, which has fixed priority and is never stalled;
  - the long-latency multiply/divide unit (MDU), which uses a valid/ready handshake.
- Keeps a 32-entry busy scoreboard of MDU destinations for the hazard unit.
- Raises a pipeline stall request when the MDU has been starved too long.

Parameters:
- XLEN, 32, data width of the write port.
- MAX_WAIT, 4, number of consecutive blocked MDU cycles before stall_req is raised; legal range 1..15.
- CNT_W, $clog2(MAX_WAIT+1), width of the starvation counter; derived, not overridden.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- wb_we  in  1  write-back stage requests a register write this cycle.
- wb_rd  in  5  write-back destination register.
- wb_data  in  XLEN  write-back data.
- mdu_valid  in  1  MDU result available.
- mdu_rd  in  5  MDU destination register.
- mdu_data  in  XLEN  MDU result.
- mdu_ready  out  1  MDU result accepted this cycle (combinational).
- sb_set  in  1  issue stage dispatched an MDU op this cycle.
- sb_set_rd  in  5  destination of the dispatched MDU op.
- rf_we  out  1  register-file write enable (registered).
- rf_rd  out  5  register-file write address (registered).
- rf_wdata  out  XLEN  register-file write data (registered).
- rf_src  out  1  source of the current write: 0 = write-back, 1 = MDU (registered).
- busy  out  32  scoreboard; bit n = register xn has an MDU result outstanding.
- stall_req  out  1  request that the pipeline insert a write-back bubble (registered).

Behaviour:
- Reset (asynchronous, rst_n low):
  - rf_we, rf_rd, rf_wdata, rf_src, busy and stall_req all 0.
  - FSM in IDLE, counter 0.
  - Takes effect mid-handshake too: a pending MDU result is not written and its busy bit is cleared.
- wb_live = wb_we && wb_rd != 0. Write-back writes to x0 never reach the port.
- mdu_ready = mdu_valid && (!wb_live || mdu_rd == 0).
  - An MDU result addressed to x0 is accepted immediately and discarded.
- Transfer happens when mdu_valid && mdu_ready. Until then the MDU holds valid, rd and data stable.
- Port select, registered, one-cycle latency:
  - wb_live: rf_we=1, rf_rd=wb_rd, rf_wdata=wb_data, rf_src=0.
  - else transfer with mdu_rd != 0: rf_we=1, rf_rd=mdu_rd, rf_wdata=mdu_data, rf_src=1.
  - otherwise: rf_we=0; rf_rd, rf_wdata and rf_src are driven to 0.
- Scoreboard, updated on the clock edge:
  - sb_set with sb_set_rd != 0 sets busy[sb_set_rd].
  - An MDU transfer clears busy[mdu_rd].
  - If set and clear target the same register on the same edge, set wins.
  - busy[0] is always 0.
  - Write-back writes never touch busy.
- FSM:
  - IDLE:
    - mdu_valid && !mdu_ready -> WAIT, counter=1.
    - A transfer stays in IDLE.
  - WAIT:
    - Transfer -> IDLE, counter=0.
    - Still blocked: counter+1. When counter+1 == MAX_WAIT -> STARVE and stall_req=1 on that edge.
    - mdu_valid dropped without a transfer (protocol violation): -> IDLE, counter=0.
  - STARVE:
    - stall_req held at 1.
    - Transfer or mdu_valid low -> IDLE, stall_req=0 on the same edge.
  - MAX_WAIT=1: the first blocked cycle goes directly from IDLE to STARVE.
- The counter saturates and never wraps.
- Write-back always has priority, even in STARVE. Starvation is resolved only by the pipeline responding to stall_req with wb_we=0.

Decomposition:
- Shared package cpu_pkg holds:
  - the rf_src_e enum (SRC_WB, SRC_MDU);
  - the arb_state_e enum (IDLE, WAIT, STARVE);
  - constants REG_ADDR_W=5 and NUM_REGS=32.
- One natural sub-module: rf_scoreboard, which holds the busy vector with set/clear/set-wins logic.
- The FSM and port mux live in the top module.

Test Plan:
- Reset mid-activity: busy=0x0000_0024, state STARVE; pulse rst_n low -> all outputs 0 immediately; after release, busy=0, stall_req=0.
- Write-back only: wb_we=1, wb_rd=5, wb_data=0xDEADBEEF -> next cycle rf_we=1, rf_rd=5, rf_wdata=0xDEADBEEF, rf_src=0. With wb_rd=0 -> rf_we=0.
- Idle-port MDU: sb_set with rd=7 -> busy[7]=1. Later mdu_valid, rd=7, data=0x1234 with wb_we=0 -> mdu_ready=1 same cycle; next cycle rf_rd=7, rf_wdata=0x1234, rf_src=1, busy[7]=0.
- Starvation with MAX_WAIT=4: hold mdu_valid, rd=9 while wb_we=1, rd=3 for 4 cycles -> stall_req=1 after the 4th edge. Drop wb_we -> transfer, stall_req=0 and busy[9]=0 on the same edge.
- Simultaneous set and clear: MDU transfer to rd=12 while sb_set with rd=12 -> busy[12] stays 1. MDU result to x0 while wb_we=1 -> mdu_ready=1 and no rf write from the MDU.
- Conflict resolution: wb_we=1, rd=4 and mdu_valid, rd=6 in the same cycle -> write-back wins and mdu_ready=0. Next cycle with wb_we=0 -> MDU written, FSM returns to IDLE, counter 0.

Source files
------------

// File: rtl/rf_write_arbiter_pkg.sv
// cpu_pkg: shared register-file types and constants (write source, arbiter state, register addressing).
package cpu_pkg;
    localparam int REG_ADDR_W = 5;
    localparam int NUM_REGS   = 32;
    typedef enum logic {SRC_WB = 1'b0, SRC_MDU = 1'b1} rf_src_e;
    typedef enum logic [1:0] {IDLE, WAIT, STARVE} arb_state_e;
endpackage

// File: rtl/rf_write_arbiter_if.sv
// rf_write_arbiter_if: write-back, MDU handshake, scoreboard-set and register-file write bundle.
//   master: pipeline side (drives wb_*, mdu_valid/rd/data, sb_set*; observes the rest)
//   slave : arbiter side (drives mdu_ready, rf_*, busy, stall_req)
interface rf_write_arbiter_if #(parameter int XLEN = 32);
    logic                               wb_we;
    logic [cpu_pkg::REG_ADDR_W-1:0]     wb_rd;
    logic [XLEN-1:0]                    wb_data;
    logic                               mdu_valid;
    logic [cpu_pkg::REG_ADDR_W-1:0]     mdu_rd;
    logic [XLEN-1:0]                    mdu_data;
    logic                               mdu_ready;
    logic                               sb_set;
    logic [cpu_pkg::REG_ADDR_W-1:0]     sb_set_rd;
    logic                               rf_we;
    logic [cpu_pkg::REG_ADDR_W-1:0]     rf_rd;
    logic [XLEN-1:0]                    rf_wdata;
    logic                               rf_src;
    logic [cpu_pkg::NUM_REGS-1:0]       busy;
    logic                               stall_req;
    modport master (
        output wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, sb_set, sb_set_rd,
        input  mdu_ready, rf_we, rf_rd, rf_wdata, rf_src, busy, stall_req
    );
    modport slave (
        input  wb_we, wb_rd, wb_data, mdu_valid, mdu_rd, mdu_data, sb_set, sb_set_rd,
        output mdu_ready, rf_we, rf_rd, rf_wdata, rf_src, busy, stall_req
    );
endinterface

// File: rtl/rf_write_arbiter_scoreboard.sv
// rf_scoreboard: busy bit per register for outstanding MDU results.
//   set/set_rd: mark a register busy; clr/clr_rd: MDU result written; busy: vector, bit 0 tied low.
module rf_scoreboard import cpu_pkg::*; (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  set,
    input  logic [REG_ADDR_W-1:0] set_rd,
    input  logic                  clr,
    input  logic [REG_ADDR_W-1:0] clr_rd,
    output logic [NUM_REGS-1:0]   busy
);
    logic [NUM_REGS-1:0] busy_d;
    // Clear first so a same-edge set of the same register wins.
    always_comb begin
        busy_d = busy;
        if (clr) busy_d[clr_rd] = 1'b0;
        if (set) busy_d[set_rd] = 1'b1;
        busy_d[0] = 1'b0;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_d;
    end
endmodule

// File: rtl/rf_write_arbiter.sv
// rf_write_arbiter: shares the register-file write port between write-back (fixed priority) and the MDU.
//   clk, rst_n: clock and async active-low reset; bus: slave side of rf_write_arbiter_if.
module rf_write_arbiter import cpu_pkg::*; #(
    parameter  int XLEN     = 32,
    parameter  int MAX_WAIT = 4,
    localparam int CNT_W    = $clog2(MAX_WAIT + 1)
) (
    input logic           clk,
    input logic           rst_n,
    rf_write_arbiter_if.slave bus
);
    logic                  wb_live, xfer, blocked, we_d;
    logic [REG_ADDR_W-1:0] rd_d;
    logic [XLEN-1:0]       wdata_d;
    rf_src_e               src_d;
    arb_state_e            state, state_d;
    logic [CNT_W-1:0]      cnt, cnt_d;
    assign wb_live       = bus.wb_we && bus.wb_rd != '0;
    // x0 results never need the port, so they are accepted even under write-back.
    assign bus.mdu_ready = bus.mdu_valid && (!wb_live || bus.mdu_rd == '0);
    assign xfer          = bus.mdu_valid && bus.mdu_ready;
    assign blocked       = bus.mdu_valid && !bus.mdu_ready;
    assign bus.stall_req = state == STARVE;
    always_comb begin
        we_d    = wb_live || (xfer && bus.mdu_rd != '0);
        src_d   = (!wb_live && we_d) ? SRC_MDU : SRC_WB;
        rd_d    = wb_live ? bus.wb_rd : (we_d ? bus.mdu_rd : '0);
        wdata_d = wb_live ? bus.wb_data : (we_d ? bus.mdu_data : '0);
    end
    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        case (state)
            IDLE: if (blocked) begin
                state_d = (MAX_WAIT == 1) ? STARVE : WAIT;
                cnt_d   = CNT_W'(1);
            end
            WAIT: if (blocked) begin
                cnt_d = cnt + CNT_W'(1);
                if (cnt_d == CNT_W'(MAX_WAIT)) state_d = STARVE;
            end else begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            // Counter stays at MAX_WAIT while starved: saturates, never wraps.
            STARVE: if (!blocked) begin
                state_d = IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            cnt          <= '0;
            bus.rf_we    <= 1'b0;
            bus.rf_rd    <= '0;
            bus.rf_wdata <= '0;
            bus.rf_src   <= SRC_WB;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            bus.rf_we    <= we_d;
            bus.rf_rd    <= rd_d;
            bus.rf_wdata <= wdata_d;
            bus.rf_src   <= src_d;
        end
    end
    rf_scoreboard u_sb (
        .clk    (clk),
        .rst_n  (rst_n),
        .set    (bus.sb_set),
        .set_rd (bus.sb_set_rd),
        .clr    (xfer),
        .clr_rd (bus.mdu_rd),
        .busy   (bus.busy)
    );
endmodule
